mmio_store_port: RTL and testbench
==================================

// Module: mmio_store_port
// PURPOSE
//  Memory-mapped output port on the CPU data-memory store bus of the 16-bit single-cycle computer.
//  Snoops memwrite/dataadr/writedata and captures every store to MATCH_ADDR into a DEPTH-entry FIFO.
//  The FIFO drains to a host-side consumer (bench, UART, LED driver) over a valid/ready handshake.
//  The CPU polls fill level and overflow at STATUS_ADDR via a combinational read port.
// PARAMETERS
//  N           16      data/address width (matches CPU word)
//  DEPTH       4       FIFO entries; power of two, >= 2
//  MATCH_ADDR  16'h40  store address that pushes data (word 64)
//  STATUS_ADDR 16'h41  load address that returns the status word
// PORTS
//  clk         in   1                 system clock, rising edge
//  reset       in   1                 asynchronous, active-low reset
//  memwrite    in   1                 CPU store strobe, valid for one cycle per store
//  dataadr     in   N                 CPU data address
//  writedata   in   N                 CPU store data
//  status_hit  out  1                 dataadr==STATUS_ADDR and !memwrite (comb); CPU read mux selects rdata
//  rdata       out  N                 status word {overflow, 0..., count} (comb)
//  out_valid   out  1                 FIFO head valid
//  out_data    out  N                 FIFO head data
//  out_ready   in   1                 consumer accepts head this cycle
//  count       out  $clog2(DEPTH)+1   current fill level
//  overflow    out  1                 sticky: a store was dropped because the FIFO was full
//  clr_ovf     in   1                 synchronous clear of overflow
// BEHAVIOUR
//  Reset (reset==0, async): wr_ptr=rd_ptr=0, count=0, overflow=0, out_valid=0, out_data=0.
//    Storage contents need no reset. Reset mid-transfer discards all entries.
//  push = memwrite && dataadr==MATCH_ADDR; pop = out_valid && out_ready.
//  Stores to any other address, including STATUS_ADDR, are ignored.
//  Latency: a push at edge k makes out_valid=1 with out_data=writedata at edge k.
//    There is no same-cycle bypass from writedata to out_data.
//  out_valid = (count!=0); out_data = mem[rd_ptr]. Both are held stable until pop.
//  Ordering: strict FIFO. Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
//  Empty: pop cannot occur; out_ready is ignored. Push and pop never coincide on the same entry.
//  Full (count==DEPTH):
//    push together with pop: both are accepted, count stays DEPTH, and the new word goes to the freed slot.
//    push without pop: the word is dropped, overflow<=1, and count and pointers are unchanged.
//  overflow is sticky until reset or clr_ovf.
//    If clr_ovf and a new overflow event coincide, set wins and overflow stays 1.
//  rdata = {overflow, {(N-1-$clog2(DEPTH)-1){1'b0}}, count}, purely combinational.
//    A status read in cycle k returns the pre-edge count, before that cycle's push or pop.
//  No X propagation on out_data while out_valid==0. The consumer must not sample out_data then.
// TESTING
//  T1 single store: reset, store 0x0096 @ addr 64, out_ready=0.
//     -> out_valid=1, out_data=0x0096, count=1 after the edge. Raise out_ready for 1 cycle -> count=0, out_valid=0.
//  T2 ordering/wrap: 10 stores of 0x0001..0x000A to addr 64, each popped after 2 cycles.
//     -> consumer sees 1..10 in order; pointers wrap twice; overflow stays 0.
//  T3 overflow: out_ready=0, stores of 0xA0..0xA4 to addr 64.
//     -> count=4, head=0xA0, overflow=1, 0xA4 lost. Pulse clr_ovf -> overflow=0.
//  T4 full push+pop: with the FIFO full of 0xA0..0xA3, store 0xB0 while out_ready=1.
//     -> 0xA0 popped, count stays 4, drain order is 0xA1,0xA2,0xA3,0xB0.
//  T5 address filter/status: stores to 63, 65, 0x0040|0x8000.
//     -> count stays 0. Load @65 with count=2 and overflow=1 -> rdata=0x8002, status_hit=1.
//  T6 async reset: assert reset low mid-cycle with count=3.
//     -> immediately count=0, out_valid=0, overflow=0. The next store after release yields count=1.

Source files
------------

// File: rtl/mmio_store_port.sv
// mmio_store_port: snoops CPU stores to MATCH_ADDR into a small FIFO that a
// host-side consumer drains over valid/ready. The CPU polls the fill level
// and the sticky overflow flag by loading from STATUS_ADDR.
module mmio_store_port #(
  parameter int             N           = 16,
  parameter int             DEPTH       = 4,
  parameter logic [N-1:0]   MATCH_ADDR  = 16'h0040,
  parameter logic [N-1:0]   STATUS_ADDR = 16'h0041
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [N-1:0]               dataadr,
  input  logic [N-1:0]               writedata,
  output logic                       status_hit,
  output logic [N-1:0]               rdata,
  output logic                       out_valid,
  output logic [N-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push, pop, full, accept;

  // Handshake decode: a push into a full FIFO only lands when a pop frees a slot.
  always_comb begin
    push   = memwrite && (dataadr == MATCH_ADDR);
    full   = (count_q == CW'(DEPTH));
    pop    = (count_q != '0) && out_ready;
    accept = push && (!full || pop);
  end

  // Next-state for pointers, fill level and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new drop beats a simultaneous clear so no overflow event is ever lost.
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state; reset discards every queued entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= writedata;
    end
  end

  // Outputs: head is gated to zero when empty so uninitialised storage never leaks.
  always_comb begin
    out_valid  = (count_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    count      = count_q;
    overflow   = overflow_q;
    status_hit = (dataadr == STATUS_ADDR) && !memwrite;
    rdata      = {overflow_q, {(N-1-CW){1'b0}}, count_q};
  end

endmodule

// File: tb/tb_mmio_store_port.sv
// Directed bench for mmio_store_port: single store, ordering with pointer
// wrap, overflow and clear, full push+pop, address filter/status read,
// and asynchronous reset mid-cycle.
module tb_mmio_store_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [15:0] dataadr;
  logic [15:0] writedata;
  logic        status_hit;
  logic [15:0] rdata;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;
  logic        clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_store_port #(
    .N(16), .DEPTH(4), .MATCH_ADDR(16'h0040), .STATUS_ADDR(16'h0041)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .status_hit(status_hit), .rdata(rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] data);
    memwrite  = 1'b1;
    dataadr   = addr;
    writedata = data;
    tick();
    memwrite  = 1'b0;
    dataadr   = 16'h0000;
    writedata = 16'h0000;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_drain [4];
    exp_drain[0] = 16'h00A1; exp_drain[1] = 16'h00A2;
    exp_drain[2] = 16'h00A3; exp_drain[3] = 16'h00B0;

    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    check("rst_count",    count,     0);
    check("rst_valid",    out_valid, 0);
    check("rst_overflow", overflow,  0);
    check("rst_data",     out_data,  0);
    reset = 1'b1;
    tick();

    // T1 single store
    store(16'h0040, 16'h0096);
    $display("[TB] T1 store 0x0096 -> count=%0d data=%h", count, out_data);
    check("t1_valid", out_valid, 1);
    check("t1_data",  out_data,  16'h0096);
    check("t1_count", count,     1);
    dataadr = 16'h0041; #1;
    check("t1_status_hit", status_hit, 1);
    check("t1_rdata",      rdata,      16'h0001);
    dataadr = 16'h0000;
    out_ready = 1'b1;
    tick();
    check("t1_pop_count", count,     0);
    check("t1_pop_valid", out_valid, 0);
    tick(); // out_ready held high on an empty FIFO must be harmless
    out_ready = 1'b0;
    check("t1_empty_pop_count", count, 0);

    // T2 ordering across two pointer wraps
    for (int i = 1; i <= 10; i++) begin
      store(16'h0040, 16'(i));
      tick(); tick();
      $display("[TB] T2 store %0d -> head=%h count=%0d", i, out_data, count);
      check("t2_head",  out_data, 32'(i));
      check("t2_count", count,    1);
      pop_one();
      check("t2_drained", count, 0);
    end
    check("t2_overflow", overflow, 0);

    // T3 overflow: fifth store is dropped
    for (int i = 0; i < 5; i++) begin
      store(16'h0040, 16'h00A0 + 16'(i));
      $display("[TB] T3 store %h -> count=%0d ovf=%0d", 16'h00A0 + 16'(i), count, overflow);
    end
    check("t3_count",    count,    4);
    check("t3_head",     out_data, 16'h00A0);
    check("t3_overflow", overflow, 1);
    dataadr = 16'h0041; #1;
    check("t3_rdata", rdata, 16'h8004);
    dataadr = 16'h0000;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_clr",       overflow, 0);
    check("t3_clr_count", count,    4);

    // T4 full: push together with pop
    memwrite = 1'b1; dataadr = 16'h0040; writedata = 16'h00B0; out_ready = 1'b1;
    tick();
    memwrite = 1'b0; dataadr = 16'h0000; writedata = 16'h0000; out_ready = 1'b0;
    $display("[TB] T4 push+pop 0x00B0 -> count=%0d head=%h ovf=%0d", count, out_data, overflow);
    check("t4_count",    count,    4);
    check("t4_head",     out_data, 16'h00A1);
    check("t4_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      $display("[TB] T4 drain %0d -> %h", i, out_data);
      check("t4_drain", out_data, 32'(exp_drain[i]));
      pop_one();
    end
    check("t4_empty", count, 0);

    // T5 address filter and status read
    store(16'h003F, 16'h1111);
    check("t5_addr63", count, 0);
    store(16'h0041, 16'h2222);
    check("t5_addr65", count, 0);
    store(16'h8040, 16'h3333);
    check("t5_addr8040", count, 0);
    check("t5_no_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) store(16'h0040, 16'h00C0 + 16'(i));
    // drop and clear in the same cycle: the drop must win
    memwrite = 1'b1; dataadr = 16'h0040; writedata = 16'h00C4; clr_ovf = 1'b1;
    tick();
    memwrite = 1'b0; dataadr = 16'h0000; writedata = 16'h0000; clr_ovf = 1'b0;
    check("t5_set_wins", overflow, 1);
    check("t5_head_c0", out_data, 16'h00C0);
    pop_one();
    check("t5_head_c1", out_data, 16'h00C1);
    pop_one();
    dataadr = 16'h0041; #1;
    $display("[TB] T5 status read -> rdata=%h hit=%0d", rdata, status_hit);
    check("t5_rdata",      rdata,      16'h8002);
    check("t5_status_hit", status_hit, 1);
    memwrite = 1'b1; #1;
    check("t5_hit_on_store", status_hit, 0);
    memwrite = 1'b0; dataadr = 16'h0000;
    tick();
    check("t5_count_after", count, 2);

    // T6 asynchronous reset mid-cycle
    store(16'h0040, 16'h00C5);
    check("t6_pre_count", count, 3);
    #2 reset = 1'b0;
    #1;
    $display("[TB] T6 async reset -> count=%0d valid=%0d ovf=%0d", count, out_valid, overflow);
    check("t6_count",    count,     0);
    check("t6_valid",    out_valid, 0);
    check("t6_overflow", overflow,  0);
    check("t6_data",     out_data,  0);
    tick();
    reset = 1'b1;
    tick();
    store(16'h0040, 16'h0055);
    $display("[TB] T6 store after reset -> count=%0d head=%h", count, out_data);
    check("t6_post_count", count,    1);
    check("t6_post_head",  out_data, 16'h0055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
